// File: rtl/md_unit.sv
// md_unit: multi-cycle mult/div unit holding HI/LO for the EX stage.
// Optional madd/maddu support is enabled by defining MD_MADD_EN.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        op_valid,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
`endif

  localparam logic [3:0] MUL_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;

  logic [63:0] sprod;
  logic [63:0] uprod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] sq_mag;
  logic [31:0] sr_mag;
  logic [31:0] squo;
  logic [31:0] srem;
  logic [31:0] uquo;
  logic [31:0] urem;
  logic        long_op;
  logic [3:0]  n_cyc;
  logic [63:0] res;

  // Arithmetic datapath: signed divide done on magnitudes so the
  // quotient truncates toward zero and the remainder follows the dividend.
  always_comb begin
    sprod  = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    uprod  = {32'd0, rs_val} * {32'd0, rt_val};
    a_neg  = rs_val[31];
    b_neg  = rt_val[31];
    a_mag  = a_neg ? (32'd0 - rs_val) : rs_val;
    b_mag  = b_neg ? (32'd0 - rt_val) : rt_val;
    sq_mag = 32'd0;
    sr_mag = 32'd0;
    uquo   = 32'd0;
    urem   = 32'd0;
    if (rt_val != 32'd0) begin
      sq_mag = a_mag / b_mag;
      sr_mag = a_mag % b_mag;
      uquo   = rs_val / rt_val;
      urem   = rs_val % rt_val;
    end
    squo = (a_neg ^ b_neg) ? (32'd0 - sq_mag) : sq_mag;
    srem = a_neg ? (32'd0 - sr_mag) : sr_mag;
  end

  // Opcode decode: which ops go busy, for how long, and their result.
  always_comb begin
    long_op = 1'b0;
    n_cyc   = 4'd0;
    res     = {hi, lo};
    case (md_op)
      OP_MULT: begin
        long_op = 1'b1;
        n_cyc   = MUL_N;
        res     = sprod;
      end
      OP_MULTU: begin
        long_op = 1'b1;
        n_cyc   = MUL_N;
        res     = uprod;
      end
      OP_DIV: begin
        long_op = 1'b1;
        n_cyc   = DIV_N;
        if (rt_val != 32'd0) res = {srem, squo};
      end
      OP_DIVU: begin
        long_op = 1'b1;
        n_cyc   = DIV_N;
        if (rt_val != 32'd0) res = {urem, uquo};
      end
`ifdef MD_MADD_EN
      OP_MADD: begin
        long_op = 1'b1;
        n_cyc   = MUL_N;
        res     = {hi, lo} + sprod;
      end
      OP_MADDU: begin
        long_op = 1'b1;
        n_cyc   = MUL_N;
        res     = {hi, lo} + uprod;
      end
`endif
      default: ;
    endcase
  end

  assign start = op_valid && (state == IDLE) && long_op;

  // Control FSM: buffer result at start, commit when the count expires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            {pend_hi, pend_lo} <= res;
            cnt   <= n_cyc;
            busy  <= 1'b1;
            state <= BUSY;
          end else if (op_valid && md_op == OP_MTHI) begin
            hi <= rs_val;
          end else if (op_valid && md_op == OP_MTLO) begin
            lo <= rs_val;
          end
        end
        BUSY: begin
          if (cnt <= 4'd1) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            cnt   <= 4'd0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vector bench for md_unit.
// Covers mult/div timing, HI/LO results, reset abort and ignored ops.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic        op_valid = 1'b0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  md_unit dut (
    .clk      (clk),
    .reset    (reset),
    .md_op    (md_op),
    .op_valid (op_valid),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .start    (start),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    int          ncyc;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    @(negedge clk);
    md_op = op;
    op_valid = 1'b1;
    rs_val = v;
    @(negedge clk);
    op_valid = 1'b0;
    md_op = 4'd0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic st);
    @(negedge clk);
    md_op = op;
    op_valid = 1'b1;
    rs_val = a;
    rt_val = b;
    #1 st = start;
    @(negedge clk);
    op_valid = 1'b0;
    md_op = 4'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic st;
    int   n;

    vecs.push_back('{4'd1, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0,
                     5, 32'hFFFFFFFF, 32'hFFFFFFFE});
    vecs.push_back('{4'd2, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0,
                     5, 32'h00000001, 32'hFFFFFFFE});
    vecs.push_back('{4'd3, 32'hFFFFFFF9, 32'h2, 32'h0, 32'h0,
                     10, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{4'd4, 32'h7, 32'h2, 32'h0, 32'h0,
                     10, 32'h1, 32'h3});
    vecs.push_back('{4'd3, 32'h1234, 32'h0, 32'h11, 32'h22,
                     10, 32'h11, 32'h22});
    vecs.push_back('{4'd4, 32'h1234, 32'h0, 32'h33, 32'h44,
                     10, 32'h33, 32'h44});
    vecs.push_back('{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h9, 32'h9,
                     10, 32'h0, 32'h80000000});
    vecs.push_back('{4'd1, 32'h3, 32'h4, 32'h7, 32'h7,
                     5, 32'h0, 32'hC});
    vecs.push_back('{4'd4, 32'hFFFFFFFF, 32'h10, 32'h0, 32'h0,
                     10, 32'hF, 32'h0FFFFFFF});
    vecs.push_back('{4'd3, 32'h7, 32'hFFFFFFFE, 32'h0, 32'h0,
                     10, 32'h1, 32'hFFFFFFFD});
    vecs.push_back('{4'd1, 32'h80000000, 32'h80000000, 32'h0, 32'h0,
                     5, 32'h40000000, 32'h0});
    vecs.push_back('{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,
                     5, 32'hFFFFFFFE, 32'h00000001});
`ifdef MD_MADD_EN
    vecs.push_back('{4'd7, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF,
                     5, 32'h1, 32'h0});
    vecs.push_back('{4'd7, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h5,
                     5, 32'h0, 32'h3});
    vecs.push_back('{4'd8, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h5,
                     5, 32'h2, 32'h3});
`endif

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      mt(4'd5, vecs[i].pre_hi);
      mt(4'd6, vecs[i].pre_lo);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, st);
      chk($sformatf("v%0d_start", i), {31'd0, st}, 32'd1);
      wait_idle(n);
      chk($sformatf("v%0d_cycles", i), n, vecs[i].ncyc);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].ehi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].elo);
    end

    // back-to-back start in the cycle busy falls
    md_op = 4'd2;
    op_valid = 1'b1;
    rs_val = 32'd2;
    rt_val = 32'd3;
    #1 chk("b2b_start", {31'd0, start}, 32'd1);
    @(negedge clk);
    op_valid = 1'b0;
    md_op = 4'd0;
    wait_idle(n);
    chk("b2b_cycles", n, 5);
    chk("b2b_hi", hi, 32'd0);
    chk("b2b_lo", lo, 32'd6);

    // mthi then mult immediately, div presented while busy
    @(negedge clk);
    md_op = 4'd5;
    op_valid = 1'b1;
    rs_val = 32'hDEADBEEF;
    #1 chk("mthi_start", {31'd0, start}, 32'd0);
    @(negedge clk);
    chk("mthi_hi", hi, 32'hDEADBEEF);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    md_op = 4'd1;
    rs_val = 32'd3;
    rt_val = 32'd4;
    #1 chk("mul_start", {31'd0, start}, 32'd1);
    @(negedge clk);
    chk("mul_busy", {31'd0, busy}, 32'd1);
    chk("mul_hold_hi", hi, 32'hDEADBEEF);
    md_op = 4'd3;
    rs_val = 32'd100;
    rt_val = 32'd7;
    #1 chk("busy_div_start", {31'd0, start}, 32'd0);
    @(negedge clk);
    op_valid = 1'b0;
    md_op = 4'd0;
    wait_idle(n);
    chk("mul_cycles", n + 1, 5);
    chk("mul_hi", hi, 32'd0);
    chk("mul_lo", lo, 32'd12);
    repeat (12) @(negedge clk);
    chk("ign_busy", {31'd0, busy}, 32'd0);
    chk("ign_lo", lo, 32'd12);

    // inactive and reserved ops
    mt(4'd5, 32'h11);
    mt(4'd6, 32'h22);
    @(negedge clk);
    md_op = 4'd5;
    op_valid = 1'b0;
    rs_val = 32'hAAAA;
    @(negedge clk);
    chk("novalid_hi", hi, 32'h11);
    md_op = 4'd9;
    op_valid = 1'b1;
    rs_val = 32'h5;
    rt_val = 32'h5;
    #1 chk("rsv9_start", {31'd0, start}, 32'd0);
    @(negedge clk);
    op_valid = 1'b0;
    md_op = 4'd0;
    chk("rsv9_busy", {31'd0, busy}, 32'd0);
    chk("rsv9_hi", hi, 32'h11);
    chk("rsv9_lo", lo, 32'h22);
`ifndef MD_MADD_EN
    issue(4'd7, 32'd1, 32'd1, st);
    chk("madd_off_start", {31'd0, st}, 32'd0);
    chk("madd_off_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("madd_off_hi", hi, 32'h11);
    chk("madd_off_lo", lo, 32'h22);
`endif

    // reset in cycle T+3 of a divide
    mt(4'd5, 32'h55);
    mt(4'd6, 32'h66);
    issue(4'd3, 32'd100, 32'd3, st);
    chk("rdiv_start", {31'd0, st}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("rdiv_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rdiv_busy", {31'd0, busy}, 32'd0);
    chk("rdiv_hi", hi, 32'd0);
    chk("rdiv_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("rdiv_post_busy", {31'd0, busy}, 32'd0);
    chk("rdiv_post_hi", hi, 32'd0);
    chk("rdiv_post_lo", lo, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
